// File: rtl/ahb_bus_arbiter.sv
// AHB bus arbiter: one-hot grant, address-phase owner and data-phase owner for up to four masters.
// Latency: request at an arbitration point -> hgrant_o next cycle; ownership follows on the next HREADY edge.
// Backpressure: hready_i=0 freezes ownership and blocks arbitration; locked or SEQ/BUSY transfers hold the grant.
// Optional feature macro: ARB_ROUND_ROBIN_EN (defined = round-robin, undefined = fixed lowest-index priority).

module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int MW             = 2,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] hbusreq_i,
  input  logic [NUM_MASTERS-1:0] hlock_i,
  input  logic [1:0]             htrans_i,
  input  logic                   hready_i,
  output logic [NUM_MASTERS-1:0] hgrant_o,
  output logic [MW-1:0]          hmaster_o,
  output logic [MW-1:0]          hmaster_d_o,
  output logic                   hmastlock_o
);

  localparam logic [1:0]    HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]    HTRANS_NONSEQ = 2'b10;
  localparam logic [MW-1:0] DEF_IDX       = MW'(DEFAULT_MASTER);

  // Granted master index (G) and the ownership pipeline.
  logic [MW-1:0]          gnt_idx_q, gnt_idx_d;
  logic [MW-1:0]          owner_q, owner_d;
  logic [MW-1:0]          downer_q, downer_d;
  logic                   mastlock_q, mastlock_d;

  // Decoded grant and arbitration qualifiers.
  logic [NUM_MASTERS-1:0] gnt_vec;
  logic                   owner_locked;
  logic                   arb_point;
  logic                   sel_vld;
  logic [MW-1:0]          sel_idx;

  // One-hot decode of the registered grant index; only legal indices are ever stored.
  always_comb begin
    gnt_vec = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      gnt_vec[i] = (gnt_idx_q == MW'(i));
    end
  end

  // The granted master holds the bus while it keeps both lock and request asserted.
  always_comb begin
    owner_locked = |(hlock_i & hbusreq_i & gnt_vec);
    arb_point    = hready_i
                 && ((htrans_i == HTRANS_IDLE) || (htrans_i == HTRANS_NONSEQ))
                 && !owner_locked;
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Round-robin pointer: last index that actually became address-phase owner.
  logic [MW-1:0] ptr_q, ptr_d;

  // Pick the requester closest after the pointer, wrapping; the pointer itself is searched last.
  always_comb begin
    int best_dist;
    int dist;
    sel_vld   = 1'b0;
    sel_idx   = DEF_IDX;
    best_dist = NUM_MASTERS;
    dist      = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      dist = (i + NUM_MASTERS - int'(ptr_q) - 1) % NUM_MASTERS;
      if (hbusreq_i[i] && (dist < best_dist)) begin
        best_dist = dist;
        sel_vld   = 1'b1;
        sel_idx   = MW'(i);
      end
    end
  end

  // Pointer advances only when a different master actually takes over the address phase.
  always_comb begin
    ptr_d = ptr_q;
    if (hready_i && (gnt_idx_q != owner_q)) begin
      ptr_d = gnt_idx_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= DEF_IDX;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: lowest requesting index wins (descending scan, last hit is the lowest).
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = DEF_IDX;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (hbusreq_i[i]) begin
        sel_vld = 1'b1;
        sel_idx = MW'(i);
      end
    end
  end
`endif

  // Next grant: re-arbitrate only at an arbitration point, park on the default master when idle.
  always_comb begin
    gnt_idx_d = gnt_idx_q;
    if (arb_point) begin
      gnt_idx_d = sel_vld ? sel_idx : DEF_IDX;
    end
  end

  // Ownership follows the current (old) grant on each HREADY edge; data owner trails by one edge.
  always_comb begin
    owner_d    = owner_q;
    downer_d   = downer_q;
    mastlock_d = mastlock_q;
    if (hready_i) begin
      owner_d    = gnt_idx_q;
      downer_d   = owner_q;
      mastlock_d = |(hlock_i & gnt_vec);
    end
  end

  // Grant and ownership registers; reset parks everything on the default master.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_idx_q  <= DEF_IDX;
      owner_q    <= DEF_IDX;
      downer_q   <= DEF_IDX;
      mastlock_q <= 1'b0;
    end else begin
      gnt_idx_q  <= gnt_idx_d;
      owner_q    <= owner_d;
      downer_q   <= downer_d;
      mastlock_q <= mastlock_d;
    end
  end

  // All outputs come straight from registers (grant via a decode of the registered index).
  always_comb begin
    hgrant_o    = gnt_vec;
    hmaster_o   = owner_q;
    hmaster_d_o = downer_q;
    hmastlock_o = mastlock_q;
  end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter: directed handover/burst/lock/wait/reset steps,
// then randomized traffic, all compared against a transaction-level reference model.
// Mode follows ARB_ROUND_ROBIN_EN when it is defined for the build.

module tb_ahb_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] hbusreq;
  logic [3:0] hlock;
  logic [1:0] htrans;
  logic       hready;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic [1:0] hmaster_d;
  logic       hmastlock;

  int total = 0;
  int bad   = 0;

  // Reference model state: granted index, owner, data owner, lock flag, RR pointer.
  int m_g, m_own, m_down, m_lock, m_p;

  ahb_bus_arbiter #(.NUM_MASTERS(4), .MW(2), .DEFAULT_MASTER(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hbusreq_i   (hbusreq),
    .hlock_i     (hlock),
    .htrans_i    (htrans),
    .hready_i    (hready),
    .hgrant_o    (hgrant),
    .hmaster_o   (hmaster),
    .hmaster_d_o (hmaster_d),
    .hmastlock_o (hmastlock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit bit_at(input logic [3:0] v, input int i);
    logic [1:0] ix;
    ix = i[1:0];
    return v[ix];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_g = 0; m_own = 0; m_down = 0; m_lock = 0; m_p = 0;
  endtask

  // One clock edge of the arbiter rules, applied to the inputs currently driven.
  task automatic model_edge();
    bit ap;
    bit found;
    int ng;
    int c;
    ap = hready && (htrans == 2'b00 || htrans == 2'b10)
         && !(bit_at(hlock, m_g) && bit_at(hbusreq, m_g));
    ng = m_g;
    if (ap) begin
      ng = 0;
      found = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      for (int k = 1; k <= 4; k++) begin
        c = (m_p + k) % 4;
        if (!found && bit_at(hbusreq, c)) begin
          ng = c;
          found = 1'b1;
        end
      end
`else
      c = 0;
      for (int i = 0; i < 4; i++) begin
        if (!found && bit_at(hbusreq, i)) begin
          ng = i;
          found = 1'b1;
        end
      end
`endif
    end
    if (hready) begin
      if (m_g != m_own) m_p = m_g;
      m_down = m_own;
      m_own  = m_g;
      m_lock = bit_at(hlock, m_g) ? 1 : 0;
    end
    m_g = ng;
  endtask

  task automatic check_model(input string tag);
    logic [3:0] exp_gnt;
    exp_gnt = 4'b0001 << m_g;
    check({tag, ".hgrant"},    32'(hgrant),    32'(exp_gnt));
    check({tag, ".hmaster"},   32'(hmaster),   32'(m_own));
    check({tag, ".hmaster_d"}, 32'(hmaster_d), 32'(m_down));
    check({tag, ".hmastlock"}, 32'(hmastlock), 32'(m_lock));
  endtask

  task automatic step(input string tag, input logic [3:0] req, input logic [3:0] lk,
                      input logic [1:0] tr, input logic rdy);
    hbusreq = req;
    hlock   = lk;
    htrans  = tr;
    hready  = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  initial begin
    logic [3:0] seen;
    rst_n   = 1'b0;
    hbusreq = 4'b0;
    hlock   = 4'b0;
    htrans  = 2'b00;
    hready  = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst.hgrant", 32'(hgrant), 32'h1);
    check("rst.hmaster", 32'(hmaster), 32'h0);
    check("rst.hmaster_d", 32'(hmaster_d), 32'h0);
    check("rst.hmastlock", 32'(hmastlock), 32'h0);
    rst_n = 1'b1;

    // Idle bus stays parked on master 0.
    for (int i = 0; i < 10; i++) begin
      step("idle", 4'b0000, 4'b0000, 2'b00, 1'b1);
      check("idle.gnt_const", 32'(hgrant), 32'h1);
      check("idle.own_const", 32'(hmaster), 32'h0);
    end

    // Master 2 single transfers: grant +1, owner +2, data owner +3.
    step("m2.c1", 4'b0100, 4'b0000, 2'b00, 1'b1);
    check("m2.gnt_at_1", 32'(hgrant), 32'h4);
    step("m2.c2", 4'b0100, 4'b0000, 2'b00, 1'b1);
    check("m2.own_at_2", 32'(hmaster), 32'h2);
    step("m2.c3", 4'b0100, 4'b0000, 2'b10, 1'b1);
    check("m2.down_at_3", 32'(hmaster_d), 32'h2);

    // Master 1 INCR4 burst; master 0 joins at beat 2 and must wait for the burst to end.
    step("b.req1", 4'b0010, 4'b0000, 2'b00, 1'b1);
    step("b.own1", 4'b0010, 4'b0000, 2'b00, 1'b1);
    check("b.gnt1", 32'(hgrant), 32'h2);
    step("b.nonseq", 4'b0010, 4'b0000, 2'b10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step("b.seq", 4'b0011, 4'b0000, 2'b11, 1'b1);
      check("b.seq_hold", 32'(hgrant), 32'h2);
    end
    step("b.end", 4'b0011, 4'b0000, 2'b00, 1'b1);
    check("b.gnt0_after", 32'(hgrant), 32'h1);

    // Wait states during the handover 1 -> 0.
    for (int i = 0; i < 3; i++) begin
      step("ws.wait", 4'b0001, 4'b0000, 2'b00, 1'b0);
      check("ws.own_frozen", 32'(hmaster), 32'h1);
    end
    step("ws.go", 4'b0001, 4'b0000, 2'b00, 1'b1);
    check("ws.own_adv", 32'(hmaster), 32'h0);
    check("ws.down_adv", 32'(hmaster_d), 32'h1);

    // Master 3 locked sequence while the others request.
    step("lk.req", 4'b1000, 4'b1000, 2'b00, 1'b1);
    check("lk.gnt3", 32'(hgrant), 32'h8);
    step("lk.own", 4'b1000, 4'b1000, 2'b10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step("lk.hold", 4'b1111, 4'b1000, 2'b10, 1'b1);
      check("lk.gnt_hold", 32'(hgrant), 32'h8);
      check("lk.mastlock", 32'(hmastlock), 32'h1);
    end
    step("lk.release", 4'b1111, 4'b0000, 2'b10, 1'b1);
    check("lk.gnt_after", 32'(hgrant), 32'h1);

    // Everyone requests single NONSEQ transfers continuously.
    seen = 4'b0;
    for (int i = 0; i < 12; i++) begin
      step("all", 4'b1111, 4'b0000, 2'b10, 1'b1);
      seen[hmaster] = 1'b1;
`ifndef ARB_ROUND_ROBIN_EN
      check("all.own0", 32'(hmaster), 32'h0);
`endif
    end
`ifdef ARB_ROUND_ROBIN_EN
    check("all.each_served", 32'(seen), 32'hF);
`endif

    // Asynchronous reset in the middle of a burst owned by master 1.
    step("mr.req", 4'b0010, 4'b0000, 2'b00, 1'b1);
    step("mr.own", 4'b0010, 4'b0000, 2'b10, 1'b1);
    step("mr.seq", 4'b0010, 4'b0000, 2'b11, 1'b1);
    htrans = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mr.hgrant", 32'(hgrant), 32'h1);
    check("mr.hmaster", 32'(hmaster), 32'h0);
    check("mr.hmaster_d", 32'(hmaster_d), 32'h0);
    check("mr.hmastlock", 32'(hmastlock), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("mr.restart", 4'b0000, 4'b0000, 2'b00, 1'b1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r;
      logic [3:0] l;
      r = 4'($urandom_range(0, 15));
      l = ($urandom_range(0, 3) == 0) ? (r & 4'($urandom_range(0, 15))) : 4'b0;
      step("rnd", r, l, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
